// File: rtl/mem_stage_ot.sv
// mem_stage_ot: memory stage with an in-order tracking queue of up to DEPTH in-flight instructions.
// Define MEM_STAGE_MISALIGN_SPLIT_EN to split word-crossing accesses into two bus transactions.
module mem_stage_ot #(
    parameter int TAG_WIDTH = 4,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 rd_wr_en_mem,
    input  logic [TAG_WIDTH-1:0] rd_wr_tag_mem,
    input  logic [4:0]           rd_wr_addr_mem,
    input  logic [31:0]          rd_wr_data_mem,
    input  logic                 lsu_en_mem,
    input  logic                 lsu_we_mem,
    input  logic [2:0]           lsu_dtype_mem,
    input  logic [31:0]          lsu_addr_mem,
    input  logic [31:0]          lsu_wdata_mem,
    input  logic                 exc_taken_mem,
    input  logic [5:0]           exc_cause_mem,
    input  logic [31:0]          exc_tval_mem,
    input  logic                 flush_M,
    output logic                 forward_mem_en,
    output logic [TAG_WIDTH-1:0] forward_mem_tag,
    output logic [4:0]           forward_mem_addr,
    output logic [31:0]          forward_mem_wdata,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic                 rd_wr_en_wb,
    output logic [TAG_WIDTH-1:0] rd_wr_tag_wb,
    output logic [4:0]           rd_wr_addr_wb,
    output logic [31:0]          rd_wr_data_wb,
    output logic                 exc_taken_wb,
    output logic [5:0]           exc_cause_wb,
    output logic [31:0]          exc_tval_wb,
    output logic                 data_req,
    output logic                 data_wr,
    output logic [31:0]          data_addr,
    output logic [31:0]          data_wdata,
    output logic [3:0]           data_be,
    input  logic                 data_gnt,
    input  logic                 data_valid,
    input  logic [31:0]          data_rdata,
    input  logic                 data_error
);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic                 valid;
        logic                 done;
        logic                 killed;
        logic                 is_ld;
        logic [2:0]           dtype;
        logic [1:0]           a;
        logic                 rd_en;
        logic [TAG_WIDTH-1:0] tag;
        logic [4:0]           rd_addr;
        logic [31:0]          data;
        logic                 exc;
        logic [5:0]           cause;
        logic [31:0]          tval;
        logic [1:0]           resp_cnt;
        logic [1:0]           need;
    } entry_t;

    entry_t        q_q [DEPTH];
    entry_t        q_d [DEPTH];
    entry_t        new_e;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d, ridx, idx, fidx;
    logic [PW:0]   cnt_q, cnt_d;
    logic          req_q, req_d, req_wr_q, req_wr_d;
    logic [31:0]   req_addr_q, req_addr_d, req_wdata_q, req_wdata_d;
    logic [3:0]    req_be_q, req_be_d;
    logic [1:0]    a;
    logic [3:0]    be_base;
    logic [31:0]   merged, raw;
    logic          misal, issue_op, push, pop, full, found, last;

    function automatic logic [31:0] ext(input logic [31:0] r, input logic [2:0] dt);
        return dt == 3'b000 ? {{24{r[7]}}, r[7:0]} :
               dt == 3'b001 ? {{16{r[15]}}, r[15:0]} :
               dt == 3'b100 ? {24'b0, r[7:0]} :
               dt == 3'b101 ? {16'b0, r[15:0]} : r;
    endfunction

    assign a       = lsu_addr_mem[1:0];
    assign be_base = lsu_dtype_mem[1:0] == 2'b00 ? 4'b0001 : lsu_dtype_mem[1:0] == 2'b01 ? 4'b0011 : 4'b1111;
    assign misal   = lsu_dtype_mem[1:0] == 2'b00 ? 1'b0 : lsu_dtype_mem[1:0] == 2'b01 ? a[0] : |a;

`ifdef MEM_STAGE_MISALIGN_SPLIT_EN
    logic [7:0]  be8;
    logic [63:0] wd64;
    logic        cross, pend2_q, pend2_d;
    logic [31:0] addr2_q, addr2_d, wdata2_q, wdata2_d;
    logic [3:0]  be2_q, be2_d;
    assign be8      = {4'b0, be_base} << a;
    assign wd64     = {32'b0, lsu_wdata_mem} << {a, 3'b000};
    assign cross    = misal & |be8[7:4];
    assign issue_op = lsu_en_mem & ~exc_taken_mem;
    assign in_ready = ~full & ~flush_M & (~req_q | data_gnt) & ~pend2_q;
`else
    assign issue_op = lsu_en_mem & ~exc_taken_mem & ~misal;
    assign in_ready = ~full & ~flush_M & (~req_q | data_gnt);
`endif

    assign full     = cnt_q == (PW+1)'(DEPTH);
    assign push     = in_valid & in_ready;
    assign wb_valid = q_q[head_q].valid & q_q[head_q].done & ~q_q[head_q].killed;
    assign pop      = q_q[head_q].valid & q_q[head_q].done & (q_q[head_q].killed | wb_ready);

    always_comb begin
        new_e         = '0;
        new_e.valid   = 1'b1;
        new_e.done    = ~issue_op;
        new_e.is_ld   = lsu_en_mem & ~lsu_we_mem;
        new_e.dtype   = lsu_dtype_mem;
        new_e.a       = a;
        new_e.rd_en   = rd_wr_en_mem & ~(lsu_en_mem & lsu_we_mem) & ~exc_taken_mem;
        new_e.tag     = rd_wr_tag_mem;
        new_e.rd_addr = rd_wr_addr_mem;
        new_e.data    = rd_wr_data_mem;
        new_e.exc     = exc_taken_mem;
        new_e.cause   = exc_cause_mem;
        new_e.tval    = exc_taken_mem ? exc_tval_mem : lsu_addr_mem;
`ifdef MEM_STAGE_MISALIGN_SPLIT_EN
        new_e.need    = cross ? 2'd2 : 2'd1;
`else
        new_e.need    = 2'd1;
        if (lsu_en_mem && !exc_taken_mem && misal) begin
            new_e.exc   = 1'b1;
            new_e.cause = lsu_we_mem ? 6'd6 : 6'd4;
            new_e.rd_en = 1'b0;
        end
`endif
    end

    // Responses return in order, so they belong to the oldest entry still waiting.
    always_comb begin
        found = 1'b0;
        ridx  = head_q;
        idx   = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (!found && q_q[idx].valid && !q_q[idx].done) begin
                found = 1'b1;
                ridx  = idx;
            end
        end
    end

    assign merged = 32'({data_rdata, q_q[ridx].data} >> {q_q[ridx].a, 3'b000});
    assign raw    = q_q[ridx].need == 2'd2 ? merged : data_rdata >> {q_q[ridx].a, 3'b000};
    assign last   = q_q[ridx].resp_cnt + 2'd1 == q_q[ridx].need;

    always_comb begin
        q_d         = q_q;
        head_d      = head_q;
        tail_d      = tail_q;
        req_d       = req_q & ~data_gnt;
        req_wr_d    = req_wr_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_be_d    = req_be_q;
`ifdef MEM_STAGE_MISALIGN_SPLIT_EN
        pend2_d     = pend2_q;
        addr2_d     = addr2_q;
        wdata2_d    = wdata2_q;
        be2_d       = be2_q;
        if (req_q && data_gnt && pend2_q) begin
            req_d       = 1'b1;
            req_addr_d  = addr2_q;
            req_wdata_d = wdata2_q;
            req_be_d    = be2_q;
            pend2_d     = 1'b0;
        end
`endif
        if (push && issue_op) begin
            req_d      = 1'b1;
            req_wr_d   = lsu_we_mem;
            req_addr_d = {lsu_addr_mem[31:2], 2'b00};
`ifdef MEM_STAGE_MISALIGN_SPLIT_EN
            req_wdata_d = wd64[31:0];
            req_be_d    = be8[3:0];
            pend2_d     = cross;
            addr2_d     = {lsu_addr_mem[31:2] + 30'd1, 2'b00};
            wdata2_d    = wd64[63:32];
            be2_d       = be8[7:4];
`else
            req_wdata_d = lsu_wdata_mem << {a, 3'b000};
            req_be_d    = be_base << a;
`endif
        end
        if (data_valid && found) begin
            q_d[ridx].resp_cnt = q_q[ridx].resp_cnt + 2'd1;
            q_d[ridx].done     = last;
            if (q_q[ridx].is_ld)
                q_d[ridx].data = last ? ext(raw, q_q[ridx].dtype) : data_rdata;
            if (data_error) begin
                q_d[ridx].exc   = 1'b1;
                q_d[ridx].cause = q_q[ridx].is_ld ? 6'd5 : 6'd7;
                q_d[ridx].rd_en = 1'b0;
            end
        end
        if (flush_M)
            for (int i = 0; i < DEPTH; i++)
                if (q_q[i].valid) q_d[i].killed = 1'b1;
        if (pop) begin
            q_d[head_q].valid = 1'b0;
            head_d            = head_q + 1'b1;
        end
        if (push) begin
            q_d[tail_q] = new_e;
            tail_d      = tail_q + 1'b1;
        end
        cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end

    // Youngest forwardable result wins; a younger incomplete load hides older results.
    always_comb begin
        forward_mem_en    = 1'b0;
        forward_mem_tag   = '0;
        forward_mem_addr  = '0;
        forward_mem_wdata = '0;
        fidx              = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            fidx = head_q + PW'(i);
            if (q_q[fidx].valid && !q_q[fidx].killed) begin
                if (q_q[fidx].done && q_q[fidx].rd_en && !q_q[fidx].is_ld) begin
                    forward_mem_en    = 1'b1;
                    forward_mem_tag   = q_q[fidx].tag;
                    forward_mem_addr  = q_q[fidx].rd_addr;
                    forward_mem_wdata = q_q[fidx].data;
                end else if (q_q[fidx].is_ld && !q_q[fidx].done) begin
                    forward_mem_en = 1'b0;
                end
            end
        end
    end

    assign rd_wr_en_wb   = wb_valid & q_q[head_q].rd_en;
    assign rd_wr_tag_wb  = wb_valid ? q_q[head_q].tag : '0;
    assign rd_wr_addr_wb = wb_valid ? q_q[head_q].rd_addr : '0;
    assign rd_wr_data_wb = wb_valid ? q_q[head_q].data : '0;
    assign exc_taken_wb  = wb_valid & q_q[head_q].exc;
    assign exc_cause_wb  = wb_valid ? q_q[head_q].cause : '0;
    assign exc_tval_wb   = wb_valid ? q_q[head_q].tval : '0;
    assign data_req      = req_q;
    assign data_wr       = req_wr_q;
    assign data_addr     = req_addr_q;
    assign data_wdata    = req_wdata_q;
    assign data_be       = req_be_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) q_q[i] <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            req_wr_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_be_q    <= '0;
`ifdef MEM_STAGE_MISALIGN_SPLIT_EN
            pend2_q     <= 1'b0;
            addr2_q     <= '0;
            wdata2_q    <= '0;
            be2_q       <= '0;
`endif
        end else begin
            q_q         <= q_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            req_wr_q    <= req_wr_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_be_q    <= req_be_d;
`ifdef MEM_STAGE_MISALIGN_SPLIT_EN
            pend2_q     <= pend2_d;
            addr2_q     <= addr2_d;
            wdata2_q    <= wdata2_d;
            be2_q       <= be2_d;
`endif
        end
    end
endmodule
